// File: rtl/sc_dense_layer_fsm.sv
// Stochastic-computing dense layer: XNOR/APC + Btanh neurons over one frame per start pulse.
// Optional SC_LAYER_ARGMAX_EN registers the index of the largest per-neuron ones count.
//
// state | meaning
// IDLE  | waiting for start; counts and argmax hold
// RUN   | accepting samples on din_valid_i until STREAM_LEN accepted
// FLUSH | last sample's output bit is valid and gets counted
// DONE  | one-cycle done pulse; counts final
module sc_dense_layer_fsm #(
  parameter int N_IN       = 64,
  parameter int N_OUT      = 32,
  parameter int STREAM_LEN = 256,
  parameter int STATE_W    = 6,
  localparam int CNT_W     = $clog2(STREAM_LEN + 1),
  localparam int AW        = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic [N_IN-1:0]        din_i,
  input  logic                   din_valid_i,
  input  logic [N_IN-1:0]        weight_i [0:N_OUT-1],
  input  logic [N_OUT-1:0]       bias_i,
  output logic                   busy_o,
  output logic [N_OUT-1:0]       dout_o,
  output logic                   dout_valid_o,
  output logic                   done_o,
  output logic [N_OUT*CNT_W-1:0] ones_count_o,
  output logic [AW-1:0]          argmax_o
);

  localparam int SMAX = 2**STATE_W - 1;
  localparam int MID  = 2**(STATE_W-1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t             fsm_q, fsm_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept, start_clr;
  logic [STATE_W-1:0] st_q [N_OUT];
  logic [STATE_W-1:0] st_d [N_OUT];
  logic [N_OUT-1:0]   dout_q;
  logic               dout_valid_q;
  logic [CNT_W-1:0]   ones_q [N_OUT];
  logic [CNT_W-1:0]   ones_d [N_OUT];

  always_comb begin
    fsm_d     = fsm_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    start_clr = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start_i) begin
          fsm_d     = RUN;
          start_clr = 1'b1;
        end
      end
      RUN: begin
        if (din_valid_i) begin
          accept = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(STREAM_LEN - 1)) fsm_d = FLUSH;
        end
      end
      FLUSH:   fsm_d = DONE;
      default: fsm_d = IDLE;
    endcase
  end

  // Signed arithmetic in int so 2*s-(N_IN+1) plus the state cannot overflow before the clamp.
  always_comb begin
    for (int i = 0; i < N_OUT; i++) begin
      automatic int s   = 0;
      automatic int acc = 0;
      for (int b = 0; b < N_IN; b++) begin
        if (din_i[b] ~^ weight_i[i][b]) s = s + 1;
      end
      s   = s + int'(bias_i[i]);
      acc = int'(st_q[i]) + 2 * s - (N_IN + 1);
      if (acc < 0)         st_d[i] = '0;
      else if (acc > SMAX) st_d[i] = STATE_W'(SMAX);
      else                 st_d[i] = acc[STATE_W-1:0];
    end
  end

  always_comb begin
    for (int i = 0; i < N_OUT; i++) begin
      ones_d[i] = ones_q[i] + CNT_W'(dout_valid_q & dout_q[i]);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fsm_q        <= IDLE;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      for (int i = 0; i < N_OUT; i++) begin
        st_q[i]   <= STATE_W'(MID);
        ones_q[i] <= '0;
      end
    end else begin
      fsm_q        <= fsm_d;
      cnt_q        <= start_clr ? '0 : cnt_d;
      dout_valid_q <= accept;
      for (int i = 0; i < N_OUT; i++) begin
        if (start_clr) begin
          st_q[i]   <= STATE_W'(MID);
          ones_q[i] <= '0;
        end else begin
          ones_q[i] <= ones_d[i];
          if (accept) begin
            st_q[i]   <= st_d[i];
            dout_q[i] <= (st_d[i] >= STATE_W'(MID));
          end
        end
      end
    end
  end

`ifdef SC_LAYER_ARGMAX_EN
  logic [AW-1:0]    argmax_q, argmax_d;
  logic [CNT_W-1:0] best;

  // Strict compare keeps the lowest index on ties.
  always_comb begin
    argmax_d = '0;
    best     = ones_d[0];
    for (int i = 1; i < N_OUT; i++) begin
      if (ones_d[i] > best) begin
        best     = ones_d[i];
        argmax_d = AW'(i);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)             argmax_q <= '0;
    else if (start_clr)      argmax_q <= '0;
    else if (fsm_q == FLUSH) argmax_q <= argmax_d;
  end

  assign argmax_o = argmax_q;
`else
  assign argmax_o = '0;
`endif

  always_comb begin
    ones_count_o = '0;
    for (int i = 0; i < N_OUT; i++) begin
      ones_count_o[i*CNT_W +: CNT_W] = ones_q[i];
    end
  end

  assign busy_o       = (fsm_q != IDLE);
  assign done_o       = (fsm_q == DONE);
  assign dout_o       = dout_q;
  assign dout_valid_o = dout_valid_q;

endmodule
